// File: rtl/npu_conv_pkg.sv
// npu_conv_pkg: shared types for the convolve front-end.
// Holds the default pixel depth and the line-buffer state encoding.
package npu_conv_pkg;

  localparam int unsigned NPU_BIT_DEPTH = 8;

  typedef enum logic [1:0] {
    LB_IDLE   = 2'b00,
    LB_FILL   = 2'b01,
    LB_STREAM = 2'b10,
    LB_DONE   = 2'b11
  } lb_state_t;

endpackage

// File: rtl/conv_line_buffer_line_ram.sv
// line_ram: one image row of pixels.
// Combinational read, synchronous write, no reset on contents.
module line_ram
  import npu_conv_pkg::*;
#(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = NPU_BIT_DEPTH,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: two-row line buffer feeding the 3x3 convolve stage.
// Define LB_PAD_TOP_EN for zero top padding (streams from row 0).
module conv_line_buffer
  import npu_conv_pkg::*;
#(
  parameter int unsigned BIT_DEPTH  = NPU_BIT_DEPTH,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28,
  parameter int unsigned COL_W      = 5,
  parameter int unsigned ROW_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic [BIT_DEPTH-1:0] pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic                 shift_buffer,
  output logic [BIT_DEPTH-1:0] out_l1,
  output logic [BIT_DEPTH-1:0] out_l2,
  output logic [BIT_DEPTH-1:0] out_l3,
  output logic                 out_valid,
  output logic [COL_W-1:0]     out_col,
  output logic                 frame_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

`ifdef LB_PAD_TOP_EN
  localparam lb_state_t START_ST = LB_STREAM;
`else
  localparam lb_state_t START_ST = LB_FILL;
`endif

  lb_state_t state_q, state_d;

  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [BIT_DEPTH-1:0] l1_q, l1_d;
  logic [BIT_DEPTH-1:0] l2_q, l2_d;
  logic [BIT_DEPTH-1:0] l3_q, l3_d;
  logic [COL_W-1:0]     ocol_q, ocol_d;
  logic                 vld_q, vld_d;

  logic                 accept;
  logic                 col_wrap;
  logic                 frame_end;
  logic [BIT_DEPTH-1:0] line_a_rd;
  logic [BIT_DEPTH-1:0] line_b_rd;
  logic [BIT_DEPTH-1:0] top_a;
  logic [BIT_DEPTH-1:0] top_b;

  assign accept    = pix_valid & pix_ready;
  assign col_wrap  = (col_q == COL_LAST);
  assign frame_end = col_wrap & (row_q == ROW_LAST);

  // lineA holds row r-2, lineB row r-1; both shift down on accept
  line_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (BIT_DEPTH),
    .AW    (COL_W)
  ) u_line_a (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (line_b_rd),
    .raddr_i (col_q),
    .rdata_o (line_a_rd)
  );

  line_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (BIT_DEPTH),
    .AW    (COL_W)
  ) u_line_b (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (pix_in),
    .raddr_i (col_q),
    .rdata_o (line_b_rd)
  );

`ifdef LB_PAD_TOP_EN
  assign top_a = (row_q < ROW_W'(2)) ? '0 : line_a_rd;
  assign top_b = (row_q == '0) ? '0 : line_b_rd;
`else
  assign top_a = line_a_rd;
  assign top_b = line_b_rd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LB_IDLE: begin
        if (frame_start) state_d = START_ST;
      end
      LB_FILL: begin
        if (accept && col_wrap && row_q == ROW_W'(1))
          state_d = LB_STREAM;
      end
      LB_STREAM: begin
        if (accept && frame_end) state_d = LB_DONE;
      end
      LB_DONE: state_d = LB_IDLE;
      default: state_d = LB_IDLE;
    endcase
  end

  always_comb begin
    pix_ready  = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      LB_FILL:   pix_ready  = 1'b1;
      LB_STREAM: pix_ready  = shift_buffer;
      LB_DONE:   frame_done = 1'b1;
      default:   pix_ready  = 1'b0;
    endcase
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    l1_d   = l1_q;
    l2_d   = l2_q;
    l3_d   = l3_q;
    ocol_d = ocol_q;
    vld_d  = 1'b0;
    if (state_q == LB_IDLE && frame_start) begin
      col_d = '0;
      row_d = '0;
    end
    if (accept) begin
      col_d  = col_wrap ? '0 : col_q + 1'b1;
      if (col_wrap) row_d = frame_end ? '0 : row_q + 1'b1;
      l1_d   = top_a;
      l2_d   = top_b;
      l3_d   = pix_in;
      ocol_d = col_q;
      vld_d  = (state_q == LB_STREAM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      l1_q   <= '0;
      l2_q   <= '0;
      l3_q   <= '0;
      ocol_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      l1_q   <= l1_d;
      l2_q   <= l2_d;
      l3_q   <= l3_d;
      ocol_q <= ocol_d;
      vld_q  <= vld_d;
    end
  end

  assign out_l1    = l1_q;
  assign out_l2    = l2_q;
  assign out_l3    = l3_q;
  assign out_col   = ocol_q;
  assign out_valid = vld_q;

endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
Upstream feeder for the 3x3 convolve stage. Accepts a raster-order pixel stream, one pixel per handshake, and stores the two previous image rows in circular line memories. Presents three vertically aligned pixels (row r-2, r-1, r) for the current column on out_l1/out_l2/out_l3. Advances only when the convolve stage raises shift_buffer, so convolve sees one new column per shift.

Parameters:
BIT_DEPTH, 8, pixel width in bits
IMG_WIDTH, 28, pixels per row (>=2)
IMG_HEIGHT, 28, rows per frame (>=3)
COL_W, 5, column counter width, ceil(log2(IMG_WIDTH))
ROW_W, 5, row counter width, ceil(log2(IMG_HEIGHT))

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
frame_start  input  1  one-cycle pulse; begins a frame from IDLE
pix_in  input  BIT_DEPTH  incoming pixel
pix_valid  input  1  pix_in valid
pix_ready  output  1  pixel accepted when pix_valid && pix_ready
shift_buffer  input  1  convolve requests the next column
out_l1  output  BIT_DEPTH  pixel from row r-2
out_l2  output  BIT_DEPTH  pixel from row r-1
out_l3  output  BIT_DEPTH  pixel from row r
out_valid  output  1  one-cycle pulse; out_l1..3 hold a new column
out_col  output  COL_W  column index of the current output column
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset: state=IDLE; col_cnt=0; row_cnt=0; out_l1/2/3=0; out_valid=0; out_col=0; frame_done=0. Line memory contents are not cleared; FILL overwrites them before any output is used.
- States:
  - IDLE: pix_ready=0. On frame_start, go to FILL.
  - FILL (row_cnt<2): pix_ready=1.
  - STREAM (row_cnt>=2): pix_ready=shift_buffer, combinational.
  - DONE: one cycle; frame_done=1; then go to IDLE.
- On each accept, column c:
  - lineA[c]<=lineB[c]; lineB[c]<=pix_in.
  - Registered outputs: out_l1<=lineA[c], out_l2<=lineB[c], out_l3<=pix_in, out_col<=c.
  - out_valid<=1 next cycle only if state==STREAM; otherwise out_valid<=0. Latency from accept to out_valid is 1 cycle.
- Without an accept, out_valid=0 and out_l*/out_col hold their values.
- Counters:
  - col_cnt increments per accept and wraps IMG_WIDTH-1 -> 0.
  - On wrap, row_cnt increments.
  - FILL -> STREAM when row_cnt reaches 2.
  - STREAM -> DONE on accepting col IMG_WIDTH-1 of row IMG_HEIGHT-1.
- frame_start outside IDLE is ignored. pix_valid in IDLE/DONE is ignored.
- shift_buffer=1 with pix_valid=0 in STREAM produces no accept and no out_valid.
- Reset mid-frame aborts immediately; the next frame restarts in FILL.
- Per frame: (IMG_HEIGHT-2)*IMG_WIDTH out_valid pulses.

Optional Feature:
Macro LB_PAD_TOP_EN.
- Defined: frame_start goes directly to STREAM. out_l1 is forced to 0 when row_cnt<2; out_l2 is forced to 0 when row_cnt==0. Gives zero top padding; per frame there are IMG_HEIGHT*IMG_WIDTH out_valid pulses.
- Undefined: behaviour as above.

Decomposition:
- Package npu_conv_pkg holds:
  - default BIT_DEPTH;
  - lb_state_t encoding: IDLE=2'b00, FILL=2'b01, STREAM=2'b10, DONE=2'b11.
- Sub-module line_ram: IMG_WIDTH x BIT_DEPTH, combinational read, synchronous write. Instantiated twice (lineA, lineB).

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, pixel=row*16+col, pix_valid held high):
- Fill+stream, shift_buffer=1 throughout -> first out_valid gives l1=0x00, l2=0x10, l3=0x20, out_col=0. Last output is 0x13, 0x23, 0x33.
- In STREAM, drop shift_buffer for 3 cycles -> pix_ready=0, no out_valid, outputs hold. On resume, the sequence continues with no skipped or duplicated column.
- Full frame -> exactly 8 out_valid pulses, and frame_done pulses once, one cycle after pixel 0x33 is accepted.
- frame_start pulsed mid-frame -> ignored; row 3 output values are unchanged.
- rst asserted after 6 pixels, then new frame -> all outputs 0 during reset. First out_valid matches the clean-frame case.
- LB_PAD_TOP_EN defined -> first output 0,0,0x00. Row 1 col 2 output is 0,0x02,0x12. 16 out_valid pulses in total.
